// File: rtl/cfg_chain_loader.sv
// Configuration shift-chain master: serializes stream words onto the chain (LOAD)
// or recirculates the chain while packing the returned bits into words (READBACK).
module cfg_chain_loader #(
    parameter int WORD_W    = 32,
    parameter int CHAIN_LEN = 256,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic              abort,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [WORD_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              config_data_in,
    output logic              config_en,
    input  logic              config_data_out,
    output logic              busy,
    output logic              done
);

    localparam int WB_W = $clog2(WORD_W + 1);
    localparam int AW   = (CNT_W > WB_W) ? CNT_W : WB_W;

    typedef enum logic [1:0] {IDLE, LOAD, READ, FIN} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [WB_W-1:0]   wbits_q, wbits_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [WORD_W-1:0] cap_q, cap_d;
    logic [WB_W-1:0]   cap_cnt_q, cap_cnt_d;
    logic [WORD_W-1:0] m_data_q, m_data_d;
    logic              m_valid_q, m_valid_d;

    logic [AW-1:0]     rem_x, wbits_x, rem_dec_x;
    logic [CNT_W-1:0]  rem_dec;
    logic              xfer;

    assign rem_x   = AW'(rem_q);
    assign wbits_x = AW'(wbits_q);

    // Output decode from registered state; only READ recirculates the tail combinationally.
    always_comb begin
        s_ready        = 1'b0;
        config_en      = 1'b0;
        config_data_in = 1'b0;
        case (state_q)
            LOAD: begin
                s_ready        = (wbits_x <= AW'(1)) && (rem_x > wbits_x);
                config_en      = (wbits_q != '0);
                config_data_in = shreg_q[WORD_W-1];
            end
            READ: begin
                config_en      = (cap_cnt_q < WB_W'(WORD_W)) && (rem_q != '0);
                config_data_in = config_data_out;
            end
            default: ;
        endcase
    end

    assign busy    = (state_q != IDLE);
    assign done    = (state_q == FIN);
    assign m_data  = m_data_q;
    assign m_valid = m_valid_q;

    assign rem_dec   = config_en ? (rem_q - CNT_W'(1)) : rem_q;
    assign rem_dec_x = AW'(rem_dec);
    assign xfer      = ((cap_cnt_q == WB_W'(WORD_W)) || ((rem_q == '0) && (cap_cnt_q != '0)))
                       && (!m_valid_q || m_ready);

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        wbits_d   = wbits_q;
        shreg_d   = shreg_q;
        cap_d     = cap_q;
        cap_cnt_d = cap_cnt_q;
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d   = mode ? READ : LOAD;
                    rem_d     = CNT_W'(CHAIN_LEN);
                    wbits_d   = '0;
                    cap_cnt_d = '0;
                end
            end
            LOAD: begin
                if (config_en) begin
                    shreg_d = shreg_q << 1;
                    wbits_d = wbits_q - WB_W'(1);
                    rem_d   = rem_dec;
                end
                // A new word replaces the one whose last bit shifts on this same edge.
                if (s_valid && s_ready) begin
                    shreg_d = s_data;
                    wbits_d = (rem_dec_x >= AW'(WORD_W)) ? WB_W'(WORD_W) : WB_W'(rem_dec);
                end
                if (rem_dec == '0) state_d = FIN;
            end
            READ: begin
                if (config_en) begin
                    cap_d     = {cap_q[WORD_W-2:0], config_data_out};
                    cap_cnt_d = cap_cnt_q + WB_W'(1);
                    rem_d     = rem_dec;
                end
                if (xfer) begin
                    m_data_d  = cap_q << (WB_W'(WORD_W) - cap_cnt_q);
                    m_valid_d = 1'b1;
                    cap_cnt_d = '0;
                end else if (m_valid_q && m_ready) begin
                    m_valid_d = 1'b0;
                end
                if ((rem_q == '0) && (cap_cnt_q == '0) && (!m_valid_q || m_ready)) begin
                    state_d   = FIN;
                    m_valid_d = 1'b0;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort && (state_q != IDLE)) begin
            state_d   = IDLE;
            m_valid_d = 1'b0;
            wbits_d   = '0;
            cap_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rem_q     <= '0;
            wbits_q   <= '0;
            shreg_q   <= '0;
            cap_q     <= '0;
            cap_cnt_q <= '0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            wbits_q   <= wbits_d;
            shreg_q   <= shreg_d;
            cap_q     <= cap_d;
            cap_cnt_q <= cap_cnt_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
        end
    end

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Bench for cfg_chain_loader: a 64-bit and a 40-bit chain instance, each with a chain model.
module tb_cfg_chain_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, mode, abort, s_valid, m_ready, sel;
    logic [31:0] s_data;

    logic        s_ready64, m_valid64, cdi64, en64, busy64, done64;
    logic [31:0] m_data64;
    logic        s_ready40, m_valid40, cdi40, en40, busy40, done40;
    logic [31:0] m_data40;

    logic [63:0] chain64 = '0;
    logic [39:0] chain40 = '0;

    always @(posedge clk) if (en64) chain64 <= {chain64[62:0], cdi64};
    always @(posedge clk) if (en40) chain40 <= {chain40[38:0], cdi40};

    cfg_chain_loader #(.WORD_W(32), .CHAIN_LEN(64)) u_dut64 (
        .clk(clk), .rst(rst), .start(start && !sel), .mode(mode), .abort(abort && !sel),
        .s_data(s_data), .s_valid(s_valid && !sel), .s_ready(s_ready64),
        .m_data(m_data64), .m_valid(m_valid64), .m_ready(m_ready),
        .config_data_in(cdi64), .config_en(en64), .config_data_out(chain64[63]),
        .busy(busy64), .done(done64));

    cfg_chain_loader #(.WORD_W(32), .CHAIN_LEN(40)) u_dut40 (
        .clk(clk), .rst(rst), .start(start && sel), .mode(mode), .abort(abort && sel),
        .s_data(s_data), .s_valid(s_valid && sel), .s_ready(s_ready40),
        .m_data(m_data40), .m_valid(m_valid40), .m_ready(m_ready),
        .config_data_in(cdi40), .config_en(en40), .config_data_out(chain40[39]),
        .busy(busy40), .done(done40));

    wire        s_ready = sel ? s_ready40 : s_ready64;
    wire        m_valid = sel ? m_valid40 : m_valid64;
    wire [31:0] m_data  = sel ? m_data40  : m_data64;
    wire        en      = sel ? en40      : en64;
    wire        cdi     = sel ? cdi40     : cdi64;
    wire        busy    = sel ? busy40    : busy64;
    wire        done    = sel ? done40    : done64;

    int          cyc = 0;
    int          en_cnt, done_cnt, acc_cnt, sr_late, first_en, last_en, done_cyc;
    logic [63:0] stream;
    logic [31:0] rb[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (en) begin
            if (en_cnt == 0) first_en <= cyc;
            last_en <= cyc;
            en_cnt  <= en_cnt + 1;
            stream  <= {stream[62:0], cdi};
        end
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (busy && acc_cnt >= 2 && s_ready) sr_late <= sr_late + 1;
        if (s_valid && s_ready) acc_cnt <= acc_cnt + 1;
        if (m_valid && m_ready) rb.push_back(m_data);
    end

    int n_cmp = 0, n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        en_cnt = 0; done_cnt = 0; acc_cnt = 0; sr_late = 0;
        first_en = 0; last_en = 0; done_cyc = 0; stream = '0;
        rb.delete();
    endtask

    task automatic send(input logic [31:0] w);
        bit ok;
        ok = 1'b0;
        s_data  = w;
        s_valid = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (s_ready) ok = 1'b1;
            tick();
        end
        if (!ok) chk("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 400 && done_cnt == 0; i++) tick();
        if (done_cnt == 0) chk("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic do_load(input logic [31:0] w0, input logic [31:0] w1, input int gap);
        start = 1'b1; mode = 1'b0;
        tick();
        start = 1'b0;
        send(w0);
        if (gap > 0) begin
            s_valid = 1'b0;
            for (int i = 0; i < 100 && !s_ready; i++) tick();
            repeat (gap) tick();
        end
        send(w1);
        s_data = 32'hFFFF_FFFF;    // keep offering junk; it must never be taken
        wait_done();
        s_valid = 1'b0;
        tick(); tick();
    endtask

    task automatic do_read(input logic rdy);
        m_ready = rdy;
        start = 1'b1; mode = 1'b1;
        tick();
        start = 1'b0;
        wait_done();
        tick(); tick();
    endtask

    function automatic logic [63:0] cur_chain();
        return sel ? {24'h0, chain40} : chain64;
    endfunction

    typedef struct {
        bit          sel;
        logic [31:0] w0;
        logic [31:0] w1;
        int          gap;
        logic [63:0] chain;
        logic [31:0] rb1;
    } vec_t;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t        vecs[4];
        int          len;
        logic [63:0] mask;
        int          e;

        vecs[0] = '{1'b0, 32'hA5A5_0001, 32'h8000_00FF, 0, 64'hA5A5_0001_8000_00FF, 32'h8000_00FF};
        vecs[1] = '{1'b1, 32'h1234_5678, 32'hFF00_0000, 0, 64'h12_3456_78FF,        32'hFF00_0000};
        vecs[2] = '{1'b0, 32'hDEAD_BEEF, 32'h0123_4567, 5, 64'hDEAD_BEEF_0123_4567, 32'h0123_4567};
        vecs[3] = '{1'b1, 32'hFFFF_FFFF, 32'h5A12_3456, 2, 64'hFF_FFFF_FF5A,        32'h5A00_0000};

        rst = 1'b1; start = 1'b0; mode = 1'b0; abort = 1'b0;
        s_valid = 1'b0; s_data = '0; m_ready = 1'b0; sel = 1'b0;
        clear_mon();
        repeat (3) tick();
        chk("rst64_ctl",   {58'd0, s_ready64, m_valid64, cdi64, en64, busy64, done64}, 64'd0);
        chk("rst64_mdata", {32'd0, m_data64}, 64'd0);
        chk("rst40_ctl",   {58'd0, s_ready40, m_valid40, cdi40, en40, busy40, done40}, 64'd0);
        chk("rst40_mdata", {32'd0, m_data40}, 64'd0);
        rst = 1'b0;
        tick();

        foreach (vecs[k]) begin
            sel  = vecs[k].sel;
            len  = sel ? 40 : 64;
            mask = (len == 64) ? {64{1'b1}} : ((64'd1 << len) - 64'd1);
            clear_mon();
            do_load(vecs[k].w0, vecs[k].w1, vecs[k].gap);
            chk("load_en_cnt", 64'(en_cnt), 64'(len));
            chk("load_span",   64'(last_en - first_en + 1), 64'(len + vecs[k].gap));
            chk("load_done_at", 64'(done_cyc), 64'(last_en + 1));
            chk("load_done_cnt", 64'(done_cnt), 64'd1);
            chk("load_accepts", 64'(acc_cnt), 64'd2);
            chk("load_sready_late", 64'(sr_late), 64'd0);
            chk("load_stream", stream & mask, vecs[k].chain);
            chk("load_chain",  cur_chain(), vecs[k].chain);
            chk("load_idle",   {63'd0, busy}, 64'd0);

            clear_mon();
            do_read(1'b1);
            chk("rb_count", 64'(rb.size()), 64'd2);
            chk("rb_word0", {32'd0, (rb.size() > 0) ? rb[0] : 32'hxxxx_xxxx}, {32'd0, vecs[k].w0});
            chk("rb_word1", {32'd0, (rb.size() > 1) ? rb[1] : 32'hxxxx_xxxx}, {32'd0, vecs[k].rb1});
            chk("rb_chain", cur_chain(), vecs[k].chain);
            chk("rb_done_cnt", 64'(done_cnt), 64'd1);
            chk("rb_en_cnt", 64'(en_cnt), 64'(len));
        end

        // Backpressure: the first word is held while the second capture fills and stalls.
        sel = 1'b0;
        clear_mon();
        do_load(32'hA5A5_0001, 32'h8000_00FF, 0);
        clear_mon();
        m_ready = 1'b0;
        start = 1'b1; mode = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 100 && !m_valid; i++) tick();
        repeat (34) tick();
        for (int i = 0; i < 10; i++) begin
            chk("bp_hold", {30'd0, m_valid, en, m_data}, {30'd0, 1'b1, 1'b0, 32'hA5A5_0001});
            tick();
        end
        m_ready = 1'b1;
        wait_done();
        tick(); tick();
        chk("bp_rb_count", 64'(rb.size()), 64'd2);
        chk("bp_rb_word0", {32'd0, (rb.size() > 0) ? rb[0] : 32'hxxxx_xxxx}, 64'hA5A5_0001);
        chk("bp_rb_word1", {32'd0, (rb.size() > 1) ? rb[1] : 32'hxxxx_xxxx}, 64'h8000_00FF);
        chk("bp_chain", chain64, 64'hA5A5_0001_8000_00FF);
        chk("bp_en_cnt", 64'(en_cnt), 64'd64);

        // Abort mid-load, with a simultaneous start that must be ignored.
        clear_mon();
        start = 1'b1; mode = 1'b0;
        s_data = 32'hA5A5_0001; s_valid = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 100 && en_cnt < 17; i++) tick();
        chk("abort_reached17", 64'(en_cnt), 64'd17);
        abort = 1'b1; start = 1'b1;
        tick();
        abort = 1'b0; start = 1'b0; s_valid = 1'b0;
        chk("abort_outputs", {60'd0, busy, en, s_ready, m_valid}, 64'd0);
        e = en_cnt;
        repeat (3) tick();
        chk("abort_stay_idle", {63'd0, busy}, 64'd0);
        chk("abort_no_shift", 64'(en_cnt), 64'(e));
        chk("abort_no_done", 64'(done_cnt), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
